// File: rtl/riscv_pipeline_pkg.sv
// Shared definitions for the pipelined RISC-V core: datapath widths, ALU and
// writeback encodings, and the control bundle carried from Decode into Execute.
package riscv_pipeline_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int COUNT_W    = 16;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } result_sel_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } decode_execute_ctrl_t;

  // An empty slot must never carry side-effecting control into Execute.
  function automatic decode_execute_ctrl_t gate_ctrl(input decode_execute_ctrl_t c,
                                                     input logic valid);
    return valid ? c : '0;
  endfunction

endpackage

// File: rtl/decode_execute_register_if.sv
// Decode-side fields in, Execute-side registered copies and stall requests out.
// validDecode/validExecute mark whether a slot holds a real instruction; there is no ready.
interface decode_execute_register_if #(
  parameter int XLEN       = riscv_pipeline_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pipeline_pkg::REG_ADDR_W,
  parameter int COUNT_W    = riscv_pipeline_pkg::COUNT_W
);
  logic                  validDecode;
  logic [XLEN-1:0]       pcDecode;
  logic [REG_ADDR_W-1:0] rs1Decode;
  logic [REG_ADDR_W-1:0] rs2Decode;
  logic [REG_ADDR_W-1:0] rdDecode;
  logic                  usesRs1Decode;
  logic                  usesRs2Decode;
  logic [XLEN-1:0]       readData1Decode;
  logic [XLEN-1:0]       readData2Decode;
  logic [XLEN-1:0]       immediateDecode;
  logic [3:0]            aluControlDecode;
  logic                  aluSrcDecode;
  logic [1:0]            resultSelectDecode;
  logic                  registerWriteEnableDecode;
  logic                  memoryReadDecode;
  logic                  memoryWriteDecode;
  logic                  branchDecode;
  logic                  jumpDecode;
  logic                  flushExecute;
  logic                  stallExternal;

  logic                  stallFetch;
  logic                  stallDecode;
  logic                  validExecute;
  logic [XLEN-1:0]       pcExecute;
  logic [XLEN-1:0]       readData1Execute;
  logic [XLEN-1:0]       readData2Execute;
  logic [XLEN-1:0]       immediateExecute;
  logic [REG_ADDR_W-1:0] rs1Execute;
  logic [REG_ADDR_W-1:0] rs2Execute;
  logic [REG_ADDR_W-1:0] rdExecute;
  logic [3:0]            aluControlExecute;
  logic                  aluSrcExecute;
  logic [1:0]            resultSelectExecute;
  logic                  registerWriteEnableExecute;
  logic                  memoryReadExecute;
  logic                  memoryWriteExecute;
  logic                  branchExecute;
  logic                  jumpExecute;
  logic [COUNT_W-1:0]    bubbleCount;

  modport master (
    output validDecode, pcDecode, rs1Decode, rs2Decode, rdDecode,
           usesRs1Decode, usesRs2Decode, readData1Decode, readData2Decode,
           immediateDecode, aluControlDecode, aluSrcDecode, resultSelectDecode,
           registerWriteEnableDecode, memoryReadDecode, memoryWriteDecode,
           branchDecode, jumpDecode, flushExecute, stallExternal,
    input  stallFetch, stallDecode, validExecute, pcExecute, readData1Execute,
           readData2Execute, immediateExecute, rs1Execute, rs2Execute, rdExecute,
           aluControlExecute, aluSrcExecute, resultSelectExecute,
           registerWriteEnableExecute, memoryReadExecute, memoryWriteExecute,
           branchExecute, jumpExecute, bubbleCount
  );

  modport slave (
    input  validDecode, pcDecode, rs1Decode, rs2Decode, rdDecode,
           usesRs1Decode, usesRs2Decode, readData1Decode, readData2Decode,
           immediateDecode, aluControlDecode, aluSrcDecode, resultSelectDecode,
           registerWriteEnableDecode, memoryReadDecode, memoryWriteDecode,
           branchDecode, jumpDecode, flushExecute, stallExternal,
    output stallFetch, stallDecode, validExecute, pcExecute, readData1Execute,
           readData2Execute, immediateExecute, rs1Execute, rs2Execute, rdExecute,
           aluControlExecute, aluSrcExecute, resultSelectExecute,
           registerWriteEnableExecute, memoryReadExecute, memoryWriteExecute,
           branchExecute, jumpExecute, bubbleCount
  );
endinterface

// File: rtl/load_use_hazard_detect.sv
// Flags a Decode instruction that reads the destination of a load still in Execute.
// x0 is never a real producer, so a load to x0 cannot create a hazard.
module load_use_hazard_detect #(
  parameter int REG_ADDR_W = riscv_pipeline_pkg::REG_ADDR_W
) (
  input  logic                  valid_execute,
  input  logic                  mem_read_execute,
  input  logic [REG_ADDR_W-1:0] rd_execute,
  input  logic                  valid_decode,
  input  logic                  uses_rs1_decode,
  input  logic [REG_ADDR_W-1:0] rs1_decode,
  input  logic                  uses_rs2_decode,
  input  logic [REG_ADDR_W-1:0] rs2_decode,
  output logic                  load_use_hazard
);
  logic producer_is_load;
  logic rs1_match;
  logic rs2_match;

  assign producer_is_load = valid_execute && mem_read_execute && (rd_execute != '0);
  assign rs1_match        = uses_rs1_decode && (rs1_decode == rd_execute);
  assign rs2_match        = uses_rs2_decode && (rs2_decode == rd_execute);
  assign load_use_hazard  = producer_is_load && valid_decode && (rs1_match || rs2_match);
endmodule

// File: rtl/decode_execute_register.sv
// Decode-to-Execute pipeline register: captures Decode each cycle, bubbles on
// load-use, holds on downstream stall, squashes on flush, counts load-use bubbles.
module decode_execute_register #(
  parameter int XLEN       = riscv_pipeline_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pipeline_pkg::REG_ADDR_W,
  parameter int COUNT_W    = riscv_pipeline_pkg::COUNT_W
) (
  input logic clk,
  input logic reset,
  decode_execute_register_if.slave bus
);
  import riscv_pipeline_pkg::decode_execute_ctrl_t;
  import riscv_pipeline_pkg::gate_ctrl;

  logic                  valid_q;
  decode_execute_ctrl_t  ctrl_q;
  decode_execute_ctrl_t  ctrl_in;
  decode_execute_ctrl_t  ctrl_d;
  logic [XLEN-1:0]       pc_q;
  logic [XLEN-1:0]       rd1_q;
  logic [XLEN-1:0]       rd2_q;
  logic [XLEN-1:0]       imm_q;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [3:0]            alu_q;
  logic                  alu_src_q;
  logic [1:0]            result_sel_q;
  logic [COUNT_W-1:0]    count_q;
  logic                  hazard;
  logic                  stall;

  load_use_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .valid_execute    (valid_q),
    .mem_read_execute (ctrl_q.mem_read),
    .rd_execute       (rd_q),
    .valid_decode     (bus.validDecode),
    .uses_rs1_decode  (bus.usesRs1Decode),
    .rs1_decode       (bus.rs1Decode),
    .uses_rs2_decode  (bus.usesRs2Decode),
    .rs2_decode       (bus.rs2Decode),
    .load_use_hazard  (hazard)
  );

  // A flush discards whatever Decode holds, so freezing the front end would be pointless.
  assign stall = !bus.flushExecute && (hazard || bus.stallExternal);

  assign ctrl_in = '{
    reg_write: bus.registerWriteEnableDecode,
    mem_read:  bus.memoryReadDecode,
    mem_write: bus.memoryWriteDecode,
    branch:    bus.branchDecode,
    jump:      bus.jumpDecode
  };
  assign ctrl_d = gate_ctrl(ctrl_in, bus.validDecode);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      pc_q         <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_q        <= '0;
      alu_src_q    <= 1'b0;
      result_sel_q <= '0;
      count_q      <= '0;
    end else if (bus.flushExecute) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (!bus.stallExternal) begin
      if (hazard) begin
        // Bubble: only validity and control are cleared; data fields are don't-care.
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        if (count_q != {COUNT_W{1'b1}}) count_q <= count_q + COUNT_W'(1);
      end else begin
        valid_q      <= bus.validDecode;
        ctrl_q       <= ctrl_d;
        pc_q         <= bus.pcDecode;
        rd1_q        <= bus.readData1Decode;
        rd2_q        <= bus.readData2Decode;
        imm_q        <= bus.immediateDecode;
        rs1_q        <= bus.rs1Decode;
        rs2_q        <= bus.rs2Decode;
        rd_q         <= bus.rdDecode;
        alu_q        <= bus.aluControlDecode;
        alu_src_q    <= bus.aluSrcDecode;
        result_sel_q <= bus.resultSelectDecode;
      end
    end
  end

  assign bus.stallFetch                 = stall;
  assign bus.stallDecode                = stall;
  assign bus.validExecute               = valid_q;
  assign bus.pcExecute                  = pc_q;
  assign bus.readData1Execute           = rd1_q;
  assign bus.readData2Execute           = rd2_q;
  assign bus.immediateExecute           = imm_q;
  assign bus.rs1Execute                 = rs1_q;
  assign bus.rs2Execute                 = rs2_q;
  assign bus.rdExecute                  = rd_q;
  assign bus.aluControlExecute          = alu_q;
  assign bus.aluSrcExecute              = alu_src_q;
  assign bus.resultSelectExecute        = result_sel_q;
  assign bus.registerWriteEnableExecute = ctrl_q.reg_write;
  assign bus.memoryReadExecute          = ctrl_q.mem_read;
  assign bus.memoryWriteExecute         = ctrl_q.mem_write;
  assign bus.branchExecute              = ctrl_q.branch;
  assign bus.jumpExecute                = ctrl_q.jump;
  assign bus.bubbleCount                = count_q;
endmodule

// File: tb/tb_decode_execute_register.sv
// Bench for decode_execute_register: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_decode_execute_register;
  localparam int XW   = 32;
  localparam int RW   = 5;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic clk;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [XW-1:0] pc_ctr = 32'h1000;

  decode_execute_register_if #(.XLEN(XW), .REG_ADDR_W(RW), .COUNT_W(CW)) bus ();

  decode_execute_register #(.XLEN(XW), .REG_ADDR_W(RW), .COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          m_valid, m_rw, m_mr, m_mw, m_br, m_jp, m_alusrc;
  logic [XW-1:0] m_pc, m_d1, m_d2, m_imm;
  logic [RW-1:0] m_rs1, m_rs2, m_rd;
  logic [3:0]    m_alu;
  logic [1:0]    m_rsel;
  int            m_count;

  function automatic bit model_hazard();
    bit reads_it;
    reads_it = (bus.usesRs1Decode && bus.rs1Decode == m_rd) ||
               (bus.usesRs2Decode && bus.rs2Decode == m_rd);
    return m_valid && m_mr && (m_rd != 0) && bus.validDecode && reads_it;
  endfunction

  function automatic bit model_stall();
    return !bus.flushExecute && (model_hazard() || bus.stallExternal);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      {m_valid, m_rw, m_mr, m_mw, m_br, m_jp, m_alusrc} = '0;
      {m_pc, m_d1, m_d2, m_imm} = '0;
      {m_rs1, m_rs2, m_rd} = '0;
      m_alu = '0; m_rsel = '0; m_count = 0;
    end else if (bus.flushExecute) begin
      {m_valid, m_rw, m_mr, m_mw, m_br, m_jp} = '0;
    end else if (bus.stallExternal) begin
      m_valid = m_valid;
    end else if (model_hazard()) begin
      {m_valid, m_rw, m_mr, m_mw, m_br, m_jp} = '0;
      if (m_count < MAXC) m_count = m_count + 1;
    end else begin
      m_valid = bus.validDecode;
      m_pc = bus.pcDecode; m_d1 = bus.readData1Decode; m_d2 = bus.readData2Decode;
      m_imm = bus.immediateDecode;
      m_rs1 = bus.rs1Decode; m_rs2 = bus.rs2Decode; m_rd = bus.rdDecode;
      m_alu = bus.aluControlDecode; m_alusrc = bus.aluSrcDecode; m_rsel = bus.resultSelectDecode;
      m_rw = bus.registerWriteEnableDecode & bus.validDecode;
      m_mr = bus.memoryReadDecode & bus.validDecode;
      m_mw = bus.memoryWriteDecode & bus.validDecode;
      m_br = bus.branchDecode & bus.validDecode;
      m_jp = bus.jumpDecode & bus.validDecode;
    end
  end

  // ---------------- scoreboard: every cycle out of reset ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("stallFetch", bus.stallFetch, model_stall());
      chk("stallDecode", bus.stallDecode, model_stall());
      chk("validExecute", bus.validExecute, m_valid);
      chk("pcExecute", bus.pcExecute, m_pc);
      chk("readData1Execute", bus.readData1Execute, m_d1);
      chk("readData2Execute", bus.readData2Execute, m_d2);
      chk("immediateExecute", bus.immediateExecute, m_imm);
      chk("rs1Execute", bus.rs1Execute, m_rs1);
      chk("rs2Execute", bus.rs2Execute, m_rs2);
      chk("rdExecute", bus.rdExecute, m_rd);
      chk("aluControlExecute", bus.aluControlExecute, m_alu);
      chk("aluSrcExecute", bus.aluSrcExecute, m_alusrc);
      chk("resultSelectExecute", bus.resultSelectExecute, m_rsel);
      chk("ctrlExecute", {bus.registerWriteEnableExecute, bus.memoryReadExecute,
          bus.memoryWriteExecute, bus.branchExecute, bus.jumpExecute},
          {m_rw, m_mr, m_mw, m_br, m_jp});
      chk("bubbleCount", bus.bubbleCount, m_count[CW-1:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.validDecode = 0; bus.pcDecode = '0; bus.rs1Decode = '0; bus.rs2Decode = '0;
    bus.rdDecode = '0; bus.usesRs1Decode = 0; bus.usesRs2Decode = 0;
    bus.readData1Decode = '0; bus.readData2Decode = '0; bus.immediateDecode = '0;
    bus.aluControlDecode = '0; bus.aluSrcDecode = 0; bus.resultSelectDecode = '0;
    bus.registerWriteEnableDecode = 0; bus.memoryReadDecode = 0; bus.memoryWriteDecode = 0;
    bus.branchDecode = 0; bus.jumpDecode = 0;
    bus.flushExecute = 0; bus.stallExternal = 0;
  endtask

  task automatic drive_alu(input int rd, input int rs1, input int rs2, input bit u1, input bit u2);
    pc_ctr = pc_ctr + 32'd4;
    bus.validDecode = 1; bus.pcDecode = pc_ctr;
    bus.rdDecode = RW'(rd); bus.rs1Decode = RW'(rs1); bus.rs2Decode = RW'(rs2);
    bus.usesRs1Decode = u1; bus.usesRs2Decode = u2;
    bus.readData1Decode = $urandom; bus.readData2Decode = $urandom; bus.immediateDecode = $urandom;
    bus.aluControlDecode = 4'd0; bus.aluSrcDecode = 0; bus.resultSelectDecode = 2'd0;
    bus.registerWriteEnableDecode = 1; bus.memoryReadDecode = 0; bus.memoryWriteDecode = 0;
    bus.branchDecode = 0; bus.jumpDecode = 0;
  endtask

  task automatic drive_load(input int rd, input int rs1);
    drive_alu(rd, rs1, 0, 1, 0);
    bus.aluSrcDecode = 1; bus.resultSelectDecode = 2'd1; bus.memoryReadDecode = 1;
  endtask

  task automatic rand_decode();
    bus.validDecode = ($urandom_range(0, 7) != 0);
    bus.pcDecode = $urandom;
    bus.rs1Decode = RW'($urandom_range(0, 3)); bus.rs2Decode = RW'($urandom_range(0, 3));
    bus.rdDecode = RW'($urandom_range(0, 3));
    bus.usesRs1Decode = 1'($urandom_range(0, 1)); bus.usesRs2Decode = 1'($urandom_range(0, 1));
    bus.readData1Decode = $urandom; bus.readData2Decode = $urandom; bus.immediateDecode = $urandom;
    bus.aluControlDecode = 4'($urandom_range(0, 15)); bus.aluSrcDecode = 1'($urandom_range(0, 1));
    bus.resultSelectDecode = 2'($urandom_range(0, 3));
    bus.registerWriteEnableDecode = 1'($urandom_range(0, 1));
    bus.memoryReadDecode = ($urandom_range(0, 2) == 0);
    bus.memoryWriteDecode = 1'($urandom_range(0, 1));
    bus.branchDecode = 1'($urandom_range(0, 1)); bus.jumpDecode = 1'($urandom_range(0, 1));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [XW-1:0] held_pc;
    int budget;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk); #1;
    chk("reset validExecute", bus.validExecute, 1'b0);
    chk("reset bubbleCount", bus.bubbleCount, 8'h00);
    chk("reset pcExecute", bus.pcExecute, 32'h0);
    chk("reset stallFetch", bus.stallFetch, 1'b0);

    // Normal flow: ADD x3,x1,x2
    step(); drive_alu(3, 1, 2, 1, 1);
    step(); drive_idle();
    chk("add validExecute", bus.validExecute, 1'b1);
    chk("add rdExecute", bus.rdExecute, 5'd3);
    chk("add regWrite", bus.registerWriteEnableExecute, 1'b1);
    chk("add bubbleCount", bus.bubbleCount, 8'h00);

    // Load-use: LW x5 then ADD x6,x5,x1
    drive_load(5, 1); step();
    drive_alu(6, 5, 1, 1, 1);
    @(negedge clk);
    chk("loaduse stallFetch", bus.stallFetch, 1'b1);
    chk("loaduse stallDecode", bus.stallDecode, 1'b1);
    step();
    chk("bubble validExecute", bus.validExecute, 1'b0);
    chk("bubble memRead", bus.memoryReadExecute, 1'b0);
    chk("bubble regWrite", bus.registerWriteEnableExecute, 1'b0);
    chk("bubble bubbleCount", bus.bubbleCount, 8'h01);
    step();
    chk("consumer validExecute", bus.validExecute, 1'b1);
    chk("consumer rs1Execute", bus.rs1Execute, 5'd5);
    chk("consumer rdExecute", bus.rdExecute, 5'd6);

    // Guards: LW x0 then a use of x0; unused rs2 matching a load
    drive_load(0, 1); step();
    drive_alu(7, 0, 0, 1, 1);
    @(negedge clk); chk("x0 stallFetch", bus.stallFetch, 1'b0);
    step();
    chk("x0 validExecute", bus.validExecute, 1'b1);
    chk("x0 bubbleCount", bus.bubbleCount, 8'h01);
    drive_load(8, 1); step();
    drive_alu(9, 2, 8, 1, 0);
    @(negedge clk); chk("rs2unused stallFetch", bus.stallFetch, 1'b0);
    step();
    chk("rs2unused rdExecute", bus.rdExecute, 5'd9);
    chk("rs2unused bubbleCount", bus.bubbleCount, 8'h01);

    // Flush wins over external stall and a pending load-use
    drive_load(9, 1); step();
    drive_alu(10, 9, 1, 1, 1);
    bus.flushExecute = 1; bus.stallExternal = 1;
    @(negedge clk); chk("flush stallFetch", bus.stallFetch, 1'b0);
    step();
    bus.flushExecute = 0; bus.stallExternal = 0;
    chk("flush validExecute", bus.validExecute, 1'b0);
    chk("flush bubbleCount", bus.bubbleCount, 8'h01);
    step();
    chk("after flush rdExecute", bus.rdExecute, 5'd10);

    // External stall for 3 cycles while Decode changes
    drive_alu(11, 1, 2, 1, 1); held_pc = pc_ctr; step();
    bus.stallExternal = 1;
    for (int i = 0; i < 3; i++) begin
      rand_decode();
      @(negedge clk); chk("extstall stallDecode", bus.stallDecode, 1'b1);
      step();
      chk("extstall rdExecute", bus.rdExecute, 5'd11);
      chk("extstall pcExecute", bus.pcExecute, held_pc);
    end
    bus.stallExternal = 0; drive_alu(12, 3, 4, 1, 1);
    step();
    chk("release rdExecute", bus.rdExecute, 5'd12);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rand_decode();
      bus.flushExecute = ($urandom_range(0, 9) == 0);
      bus.stallExternal = ($urandom_range(0, 7) == 0);
      step();
    end

    // Saturation: restart the count, then chain LW x5,0(x5)
    drive_idle(); reset = 1; step(); reset = 0;
    drive_load(5, 5);
    budget = 2000;
    while (m_count != MAXC - 1 && budget > 0) begin
      step(); budget--;
    end
    if (budget == 0) chk("saturation preload budget", 1'b1, 1'b0);
    chk("preload bubbleCount", bus.bubbleCount, 8'hFE);
    repeat (6) step();
    chk("saturated bubbleCount", bus.bubbleCount, 8'hFF);
    repeat (4) step();
    chk("still saturated bubbleCount", bus.bubbleCount, 8'hFF);

    // Async reset mid-stall
    drive_alu(13, 1, 2, 1, 1); step();
    bus.stallExternal = 1;
    step(); step();
    #3 reset = 1;
    #1;
    chk("async reset validExecute", bus.validExecute, 1'b0);
    chk("async reset rdExecute", bus.rdExecute, 5'd0);
    chk("async reset pcExecute", bus.pcExecute, 32'h0);
    chk("async reset regWrite", bus.registerWriteEnableExecute, 1'b0);
    chk("async reset bubbleCount", bus.bubbleCount, 8'h00);
    step();
    drive_idle(); reset = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
